// File: rtl/my_pkg.sv
// Shared types and constants for the writeback arbiter and its scoreboard.
package my_pkg;
  localparam int DATA_WIDTH       = 32;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;
endpackage

// File: rtl/wb_scoreboard.sv
// 32-entry pending-write scoreboard with set/clear ports and two bypassed
// query ports; x0 never reads busy.
module wb_scoreboard import my_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic [4:0] set_addr,
  input  logic       clr_en,
  input  logic [4:0] clr_addr,
  input  logic       acc_en,
  input  logic [4:0] acc_addr,
  input  logic [4:0] q1_addr,
  output logic       q1_busy,
  input  logic [4:0] q2_addr,
  output logic       q2_busy
);
  logic [31:0] busy;

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
    end
  end

  // In-flight LSU data (accepted now, or sitting in the write register) still
  // counts as busy until the register file holds it.
  assign q1_busy = (q1_addr != 5'd0) &&
                   (busy[q1_addr] || (acc_en && acc_addr == q1_addr) ||
                    (clr_en && clr_addr == q1_addr));
  assign q2_busy = (q2_addr != 5'd0) &&
                   (busy[q2_addr] || (acc_en && acc_addr == q2_addr) ||
                    (clr_en && clr_addr == q2_addr));

  a_no_reissue: assert property (@(posedge clk) disable iff (!rst_n)
    set_en |-> (!busy[set_addr] || (clr_en && clr_addr == set_addr)));
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU/LSU onto one registered regfile write port, with an
// anti-starvation FSM that forces LSU priority after STARVE_LIMIT blocked cycles.
module wb_arbiter import my_pkg::*; #(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_stall,
  input  logic                  lsu_valid,
  input  logic [4:0]            lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  input  logic                  iss_valid,
  input  logic [4:0]            iss_rd,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  wr_en,
  output logic [4:0]            addr_wr,
  output logic [DATA_WIDTH-1:0] data_wr
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          alu_acc, lsu_acc, wr_lsu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NORMAL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter only advances while LSU is blocked, so it cannot pass the limit:
  // reaching it moves to FORCE where lsu_ready is held high.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lsu_ready = !alu_valid;
    alu_stall = 1'b0;
    if (state == FORCE) begin
      lsu_ready = 1'b1;
      alu_stall = alu_valid;
    end
    if (!lsu_valid || lsu_ready) begin
      cnt_nxt   = '0;
      state_nxt = NORMAL;
    end else begin
      cnt_nxt = cnt + 1'b1;
      if (cnt_nxt == CW'(STARVE_LIMIT)) state_nxt = FORCE;
    end
  end

  // Grants are mutually exclusive by construction of lsu_ready/alu_stall.
  assign alu_acc = alu_valid && !alu_stall;
  assign lsu_acc = lsu_valid && lsu_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_lsu  <= 1'b0;
      addr_wr <= '0;
      data_wr <= '0;
    end else if (lsu_acc) begin
      wr_en   <= (lsu_rd != 5'd0);
      wr_lsu  <= 1'b1;
      addr_wr <= lsu_rd;
      data_wr <= lsu_data;
    end else if (alu_acc) begin
      wr_en   <= (alu_rd != 5'd0);
      wr_lsu  <= 1'b0;
      addr_wr <= alu_rd;
      data_wr <= alu_data;
    end else begin
      wr_en  <= 1'b0;
      wr_lsu <= 1'b0;
    end
  end

  wb_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (iss_valid && iss_rd != 5'd0),
    .set_addr (iss_rd),
    .clr_en   (wr_en && wr_lsu),
    .clr_addr (addr_wr),
    .acc_en   (rst_n && lsu_acc && lsu_rd != 5'd0),
    .acc_addr (lsu_rd),
    .q1_addr  (rs1_addr),
    .q1_busy  (rs1_busy),
    .q2_addr  (rs2_addr),
    .q2_busy  (rs2_busy)
  );
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes queued at drive time,
// popped by a write-port monitor; handshake/busy signals checked directly.
module tb_wb_arbiter;
  import my_pkg::*;
  localparam int DW  = DATA_WIDTH;
  localparam int LIM = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, lsu_valid, iss_valid;
  logic [4:0]    alu_rd, lsu_rd, iss_rd, rs1_addr, rs2_addr, addr_wr;
  logic [DW-1:0] alu_data, lsu_data, data_wr;
  logic          alu_stall, lsu_ready, rs1_busy, rs2_busy, wr_en;

  wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .addr_wr(addr_wr), .data_wr(data_wr)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  logic [5+DW-1:0] exp_q[$];
  logic [5+DW-1:0] mon_e;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Every registered write must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) chk("wr_unexpected", {addr_wr, 1'b1}, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", addr_wr, mon_e[5+DW-1:DW]);
        chk("wr_data", data_wr, mon_e[DW-1:0]);
      end
    end
  end

  // ALU held valid on rd=1 while LSU waits; expects LIM blocked cycles then FORCE.
  task automatic contend(input logic [4:0] lrd, input logic [DW-1:0] ld);
    lsu_valid = 1'b1; lsu_rd = lrd; lsu_data = ld;
    alu_valid = 1'b1; alu_rd = 5'd1;
    for (int i = 0; i < LIM; i++) begin
      alu_data = DW'(32'hA0 + i);
      exp_q.push_back({5'd1, alu_data});
      @(negedge clk);
      chk("blk_lsu_ready", lsu_ready, 0);
      chk("blk_alu_stall", alu_stall, 0);
      tick;
    end
    alu_data = DW'(32'hB0);
    exp_q.push_back({lrd, ld});
    @(negedge clk);
    chk("frc_lsu_ready", lsu_ready, 1);
    chk("frc_alu_stall", alu_stall, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rs1_addr = 5'd5; rs2_addr = 5'd0;
    @(negedge clk); @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", addr_wr, 0);
    chk("rst_data", data_wr, 0);
    chk("rst_lsu_ready_alu", lsu_ready, 0);
    chk("rst_alu_stall", alu_stall, 0);
    chk("rst_rs1_busy", rs1_busy, 0);
    alu_valid = 1'b0;
    #1 chk("rst_lsu_ready_idle", lsu_ready, 1);
    tick; rst_n = 1'b1;

    // ALU only
    tick; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = DW'(32'h1234);
    exp_q.push_back({5'd5, DW'(32'h1234)});
    @(negedge clk); chk("alu_stall", alu_stall, 0);
    tick; alu_valid = 1'b0;
    @(negedge clk);
    chk("alu_wr_en", wr_en, 1); chk("alu_addr", addr_wr, 5); chk("alu_data", data_wr, 32'h1234);
    tick; @(negedge clk);
    chk("idle_wr_en", wr_en, 0); chk("idle_hold_addr", addr_wr, 5);
    chk("idle_hold_data", data_wr, 32'h1234);

    // Contention twice back to back: second run proves the counter cleared
    tick;
    for (int r = 0; r < 2; r++) begin
      contend(5'd7, DW'(32'h7777 + r));
      tick; lsu_valid = 1'b0;
      exp_q.push_back({5'd1, DW'(32'hB0)});
      @(negedge clk);
      chk("rel_alu_stall", alu_stall, 0);
      chk("force_wr_addr", addr_wr, 7);
      tick;
    end
    alu_valid = 1'b0;

    // Scoreboard lifetime of rd=9
    tick; iss_valid = 1'b1; iss_rd = 5'd9; rs1_addr = 5'd9; rs2_addr = 5'd9;
    @(negedge clk); chk("sb_before_set", rs1_busy, 0);
    tick; iss_valid = 1'b0;
    @(negedge clk); chk("sb_set_rs1", rs1_busy, 1); chk("sb_set_rs2", rs2_busy, 1);
    tick; lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = DW'(32'h99);
    exp_q.push_back({5'd9, DW'(32'h99)});
    @(negedge clk); chk("sb_hs_ready", lsu_ready, 1); chk("sb_hs_busy", rs1_busy, 1);
    tick; lsu_valid = 1'b0;
    @(negedge clk); chk("sb_wr_en", wr_en, 1); chk("sb_wr_busy", rs1_busy, 1);
    tick;
    @(negedge clk); chk("sb_cleared", rs1_busy, 0);

    // x0 from ALU, issue and LSU
    tick; alu_valid = 1'b1; alu_rd = 5'd0; alu_data = DW'(32'hDEAD);
    iss_valid = 1'b1; iss_rd = 5'd0; rs1_addr = 5'd0;
    @(negedge clk); chk("x0_busy_a", rs1_busy, 0);
    tick; alu_valid = 1'b0; iss_valid = 1'b0; lsu_valid = 1'b1; lsu_rd = 5'd0;
    @(negedge clk); chk("x0_wr_en_a", wr_en, 0); chk("x0_lsu_ready", lsu_ready, 1);
    chk("x0_busy_b", rs1_busy, 0);
    tick; lsu_valid = 1'b0;
    @(negedge clk); chk("x0_wr_en_b", wr_en, 0); chk("x0_busy_c", rs1_busy, 0);

    // Same-cycle set and clear on rd=3
    tick; iss_valid = 1'b1; iss_rd = 5'd3; rs1_addr = 5'd3;
    tick; iss_valid = 1'b0; lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = DW'(32'h33);
    exp_q.push_back({5'd3, DW'(32'h33)});
    @(negedge clk); chk("sc_busy_hs", rs1_busy, 1);
    tick; lsu_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd3;
    @(negedge clk); chk("sc_wr_en", wr_en, 1); chk("sc_busy_wr", rs1_busy, 1);
    tick; iss_valid = 1'b0;
    @(negedge clk); chk("sc_set_wins", rs1_busy, 1);
    tick; lsu_valid = 1'b1; lsu_data = DW'(32'h34);
    exp_q.push_back({5'd3, DW'(32'h34)});
    tick; lsu_valid = 1'b0;
    tick;
    @(negedge clk); chk("sc_final_clear", rs1_busy, 0);

    // Reset while in FORCE
    tick; iss_valid = 1'b1; iss_rd = 5'd20; rs2_addr = 5'd20;
    tick; iss_valid = 1'b0;
    @(negedge clk); chk("rf_busy_pre", rs2_busy, 1);
    tick;
    contend(5'd12, DW'(32'hC0C0));
    void'(exp_q.pop_back());
    #1 rst_n = 1'b0;
    #1;
    chk("rf_wr_en", wr_en, 0); chk("rf_addr", addr_wr, 0); chk("rf_data", data_wr, 0);
    chk("rf_lsu_ready", lsu_ready, 0); chk("rf_alu_stall", alu_stall, 0);
    chk("rf_busy", rs2_busy, 0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("rf_no_wr", wr_en, 0);
      tick;
    end
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = DW'(32'hC1);
    exp_q.push_back({5'd12, DW'(32'hC1)});
    @(negedge clk); chk("rf_new_ready", lsu_ready, 1);
    tick; lsu_valid = 1'b0;
    @(negedge clk); chk("rf_new_wr_en", wr_en, 1); chk("rf_busy_post", rs2_busy, 0);
    tick; tick;

    chk("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
